mux_serial_sequencer: RTL and testbench
=======================================

// Module: mux_serial_sequencer
// PURPOSE
//  Upstream sequencer for the 8:1 select mux. Accepts an 8-bit word on a valid/ready
//  handshake, holds it on the mux data inputs, and steps the mux select through all
//  eight positions. The selected bit is returned on mux_y and forwarded as a serial
//  stream with valid/ready/last. Serial output is a combinational pass-through of mux_y.
// PARAMETERS
//  MSB_FIRST  0  0: index order 0..7; 1: index order 7..0
//  IDLE_GAP   0  forced dead cycles after each frame (0..15); in_ready=0 during gap
// PORTS
//  clk        in   1  rising-edge clock
//  rst_n      in   1  asynchronous active-low reset
//  in_valid   in   1  word offered on data_in
//  in_ready   out  1  sequencer can accept a word this cycle
//  data_in    in   8  word to serialise
//  mux_data   out  8  held word, drives the mux data inputs
//  mux_sel    out  3  mux select (bit-reversed index, see below)
//  mux_y      in   1  selected bit returned from the mux
//  ser_out    out  1  serial data (= mux_y)
//  ser_valid  out  1  ser_out is valid
//  ser_ready  in   1  consumer accepts ser_out
//  ser_last   out  1  current bit is the 8th bit of the frame
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, hold=0, idx=0, gap_cnt=0.
//    Outputs: in_ready=1, mux_data=0, mux_sel=0, ser_valid=0, ser_last=0.
//  - Select map: the mux picks data bit i when sel[2]=i[0], sel[1]=i[1], sel[0]=i[2].
//    mux_sel = {idx[0],idx[1],idx[2]}; idx is a registered 3-bit index.
//  - Index order: MSB_FIRST=0 -> idx starts at 0 and increments.
//    MSB_FIRST=1 -> idx starts at 7 and decrements.
//  - FSM: IDLE, SEND, GAP.
//    IDLE: in_ready=1, ser_valid=0.
//      On in_valid: hold<=data_in, idx<=start, go to SEND.
//    SEND: ser_valid=1, ser_out=mux_y.
//      ser_last=1 when idx is the final index (7, or 0 if MSB_FIRST=1).
//      No ser_ready: idx and mux_sel hold (stall, no bit lost or repeated).
//      On ser_valid&&ser_ready, not last: step idx.
//      On ser_valid&&ser_ready, last, IDLE_GAP>0: go to GAP, gap_cnt<=IDLE_GAP-1.
//      On ser_valid&&ser_ready, last, IDLE_GAP=0: go to IDLE; see back-to-back rule.
//    GAP: in_ready=0, ser_valid=0. Decrement gap_cnt; go to IDLE when gap_cnt==0.
//  - Back-to-back (IDLE_GAP=0 only):
//    In SEND, in_ready = ser_last && ser_ready.
//    If in_valid also holds, load the new word and restart idx; stay in SEND.
//    Sustained rate: 8 cycles per word.
//  - mux_data=hold at all times; hold changes only on an accepted word.
//  - in_ready=0 in SEND except the back-to-back cycle; in_valid ignored then.
//  - Reset mid-frame: frame aborted immediately; no partial bits after release.
//  - The mux is combinational, so mux_y tracks mux_sel in the same cycle.
//    Latency from word accept to first ser_valid: 1 cycle.
// TESTING
//  1. MSB_FIRST=0, IDLE_GAP=0, ser_ready=1, accept 8'hA5 -> ser_out 1,0,1,0,0,1,0,1
//     on cycles 1..8; ser_last only on cycle 8; mux_sel 000,100,010,110,001,101,011,111.
//  2. MSB_FIRST=1, word 8'h81 -> ser_out 1,0,0,0,0,0,0,1; mux_sel starts 111.
//  3. ser_ready low for 3 cycles at bit 4 of 8'h3C -> ser_out and mux_sel held;
//     stream resumes with no dropped or duplicated bit; 11 cycles total.
//  4. Back-to-back 8'hFF then 8'h00, in_valid held -> 16 consecutive valid bits,
//     in_ready pulses on the last bit of word 1 only.
//  5. IDLE_GAP=3 -> after ser_last handshake, in_ready=0 for 3 cycles,
//     then 1 in IDLE.
//  6. rst_n low at bit 5 of 8'hC3 -> outputs at reset values asynchronously;
//     next word 8'h01 serialises cleanly.

Source files
------------

// File: rtl/mux_serial_sequencer_if.sv
// mux_serial_sequencer_if: word handshake, mux drive/return and serial stream of the sequencer.
interface mux_serial_sequencer_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] data_in;
    logic [7:0] mux_data;
    logic [2:0] mux_sel;
    logic       mux_y;
    logic       ser_out;
    logic       ser_valid;
    logic       ser_ready;
    logic       ser_last;
    modport slave (
        input  in_valid, data_in, mux_y, ser_ready,
        output in_ready, mux_data, mux_sel, ser_out, ser_valid, ser_last
    );
    modport master (
        output in_valid, data_in, mux_y, ser_ready,
        input  in_ready, mux_data, mux_sel, ser_out, ser_valid, ser_last
    );
endinterface

// File: rtl/mux_serial_sequencer.sv
// mux_serial_sequencer: holds a word on an 8:1 mux and steps its select to stream the bits out serially.
module mux_serial_sequencer #(
    parameter bit          MSB_FIRST = 1'b0,
    parameter int unsigned IDLE_GAP  = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    mux_serial_sequencer_if.slave       bus
);
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
    localparam logic [2:0] START = MSB_FIRST ? 3'd7 : 3'd0;
    localparam logic [2:0] FINAL = MSB_FIRST ? 3'd0 : 3'd7;
    state_t     state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] gap_q, gap_d;
    logic       last, in_ready, load;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
        end
    end
    // Back-to-back reload only exists without a forced gap.
    assign last     = state_q == SEND && idx_q == FINAL;
    assign in_ready = state_q == IDLE || (IDLE_GAP == 0 && last && bus.ser_ready);
    assign load     = in_ready && bus.in_valid;
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        if (load) begin
            hold_d  = bus.data_in;
            idx_d   = START;
            state_d = SEND;
        end else if (state_q == SEND && bus.ser_ready) begin
            idx_d   = last ? idx_q : (MSB_FIRST ? idx_q - 3'd1 : idx_q + 3'd1);
            state_d = !last ? SEND : (IDLE_GAP > 0 ? GAP : IDLE);
            gap_d   = last ? 4'(IDLE_GAP - 1) : gap_q;
        end else if (state_q == GAP) begin
            gap_d   = gap_q == 4'd0 ? 4'd0 : gap_q - 4'd1;
            state_d = gap_q == 4'd0 ? IDLE : GAP;
        end
    end
    assign bus.in_ready  = in_ready;
    assign bus.mux_data  = hold_q;
    assign bus.mux_sel   = {idx_q[0], idx_q[1], idx_q[2]};
    assign bus.ser_out   = bus.mux_y;
    assign bus.ser_valid = state_q == SEND;
    assign bus.ser_last  = last;
endmodule

// File: tb/tb_mux_serial_sequencer.sv
// tb_mux_serial_sequencer: directed checks of three sequencer configurations driving a modelled 8:1 mux.
module tb_mux_serial_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic [2:0] sel_tab [8] = '{3'b000, 3'b100, 3'b010, 3'b110, 3'b001, 3'b101, 3'b011, 3'b111};
    mux_serial_sequencer_if b0 ();
    mux_serial_sequencer_if b1 ();
    mux_serial_sequencer_if b2 ();
    mux_serial_sequencer #(.MSB_FIRST(1'b0), .IDLE_GAP(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    mux_serial_sequencer #(.MSB_FIRST(1'b1), .IDLE_GAP(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    mux_serial_sequencer #(.MSB_FIRST(1'b0), .IDLE_GAP(3)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
    // External mux: data bit i is picked when sel = {i[0], i[1], i[2]}.
    assign b0.mux_y = b0.mux_data[{b0.mux_sel[0], b0.mux_sel[1], b0.mux_sel[2]}];
    assign b1.mux_y = b1.mux_data[{b1.mux_sel[0], b1.mux_sel[1], b1.mux_sel[2]}];
    assign b2.mux_y = b2.mux_data[{b2.mux_sel[0], b2.mux_sel[1], b2.mux_sel[2]}];
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
    initial begin
        logic [7:0] w;
        int idx_seq [11] = '{0, 1, 2, 3, 4, 4, 4, 4, 5, 6, 7};
        int rdy_seq [11] = '{1, 1, 1, 1, 0, 0, 0, 1, 1, 1, 1};
        b0.in_valid = 0; b0.data_in = 0; b0.ser_ready = 1;
        b1.in_valid = 0; b1.data_in = 0; b1.ser_ready = 1;
        b2.in_valid = 0; b2.data_in = 0; b2.ser_ready = 1;
        #1;
        check("rst_in_ready", b0.in_ready, 1);
        check("rst_mux_data", b0.mux_data, 0);
        check("rst_mux_sel", b0.mux_sel, 0);
        check("rst_ser_valid", b0.ser_valid, 0);
        check("rst_ser_last", b0.ser_last, 0);
        @(negedge clk); rst_n = 1;
        // Test 1: LSB first, 8'hA5
        w = 8'hA5;
        @(posedge clk); #1 b0.in_valid = 1; b0.data_in = w;
        @(negedge clk); check("t1_in_ready_idle", b0.in_ready, 1);
        @(posedge clk); #1 b0.in_valid = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("t1_valid%0d", k), b0.ser_valid, 1);
            check($sformatf("t1_out%0d", k), b0.ser_out, w[k]);
            check($sformatf("t1_sel%0d", k), b0.mux_sel, sel_tab[k]);
            check($sformatf("t1_last%0d", k), b0.ser_last, k == 7);
            check($sformatf("t1_in_ready%0d", k), b0.in_ready, k == 7);
        end
        @(negedge clk);
        check("t1_valid_end", b0.ser_valid, 0);
        check("t1_in_ready_end", b0.in_ready, 1);
        check("t1_mux_data", b0.mux_data, 8'hA5);
        // Test 2: MSB first, 8'h81
        w = 8'h81;
        @(posedge clk); #1 b1.in_valid = 1; b1.data_in = w;
        @(posedge clk); #1 b1.in_valid = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("t2_valid%0d", k), b1.ser_valid, 1);
            check($sformatf("t2_out%0d", k), b1.ser_out, w[7-k]);
            check($sformatf("t2_sel%0d", k), b1.mux_sel, sel_tab[7-k]);
            check($sformatf("t2_last%0d", k), b1.ser_last, k == 7);
        end
        @(negedge clk); check("t2_valid_end", b1.ser_valid, 0);
        // Test 3: stall three cycles at bit 4 of 8'h3C
        w = 8'h3C;
        @(posedge clk); #1 b0.in_valid = 1; b0.data_in = w;
        @(posedge clk); #1 b0.in_valid = 0;
        for (int c = 0; c < 11; c++) begin
            b0.ser_ready = rdy_seq[c][0];
            @(negedge clk);
            check($sformatf("t3_valid%0d", c), b0.ser_valid, 1);
            check($sformatf("t3_out%0d", c), b0.ser_out, w[idx_seq[c]]);
            check($sformatf("t3_sel%0d", c), b0.mux_sel, sel_tab[idx_seq[c]]);
            check($sformatf("t3_last%0d", c), b0.ser_last, c == 10);
            check($sformatf("t3_data%0d", c), b0.mux_data, 8'h3C);
            @(posedge clk); #1;
        end
        b0.ser_ready = 1;
        @(negedge clk); check("t3_valid_end", b0.ser_valid, 0);
        // Test 4: back-to-back 8'hFF then 8'h00
        @(posedge clk); #1 b0.in_valid = 1; b0.data_in = 8'hFF;
        @(posedge clk); #1 b0.data_in = 8'h00;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            check($sformatf("t4_valid%0d", c), b0.ser_valid, 1);
            check($sformatf("t4_out%0d", c), b0.ser_out, c < 8);
            if (c < 15) check($sformatf("t4_in_ready%0d", c), b0.in_ready, c == 7);
            if (c == 8) b0.in_valid = 0;
        end
        @(negedge clk);
        check("t4_valid_end", b0.ser_valid, 0);
        check("t4_mux_data", b0.mux_data, 8'h00);
        // Test 5: IDLE_GAP=3
        w = 8'h5A;
        @(posedge clk); #1 b2.in_valid = 1; b2.data_in = w;
        @(posedge clk); #1 b2.in_valid = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("t5_out%0d", k), b2.ser_out, w[k]);
            check($sformatf("t5_in_ready%0d", k), b2.in_ready, 0);
        end
        for (int g = 0; g < 3; g++) begin
            @(negedge clk);
            check($sformatf("t5_gap_in_ready%0d", g), b2.in_ready, 0);
            check($sformatf("t5_gap_valid%0d", g), b2.ser_valid, 0);
        end
        @(negedge clk); check("t5_idle_in_ready", b2.in_ready, 1);
        // Test 6: reset at bit 5 of 8'hC3, then 8'h01
        w = 8'hC3;
        @(posedge clk); #1 b0.in_valid = 1; b0.data_in = w;
        @(posedge clk); #1 b0.in_valid = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("t6_out%0d", k), b0.ser_out, w[k]);
        end
        #2 rst_n = 0;
        #1;
        check("t6_rst_valid", b0.ser_valid, 0);
        check("t6_rst_in_ready", b0.in_ready, 1);
        check("t6_rst_mux_data", b0.mux_data, 0);
        check("t6_rst_mux_sel", b0.mux_sel, 0);
        check("t6_rst_last", b0.ser_last, 0);
        @(negedge clk); rst_n = 1;
        @(negedge clk); check("t6_post_valid", b0.ser_valid, 0);
        w = 8'h01;
        @(posedge clk); #1 b0.in_valid = 1; b0.data_in = w;
        @(posedge clk); #1 b0.in_valid = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("t6_valid%0d", k), b0.ser_valid, 1);
            check($sformatf("t6_new_out%0d", k), b0.ser_out, k == 0);
            check($sformatf("t6_new_last%0d", k), b0.ser_last, k == 7);
        end
        @(negedge clk); check("t6_valid_end", b0.ser_valid, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
